poly_pack: RTL

- Streaming ByteEncode_d packer for the ATHOS Kyber datapath. It is the encode-side counterpart of the CBD/byte-decode path: that path unpacks 32-bit words into coefficients, and this block packs coefficients back into words.
- It accepts one coefficient per handshake and emits packed 32-bit little-endian words, for a full 256-coefficient polynomial.
- It sits between the coefficient SRAM/NTT output and the output word buffer. It is used for ciphertext compression (d=1,4,5,10,11) and key encoding (d=12).

---
 rtl/athos_pkg.sv | 31 +++
 rtl/poly_pack.sv | 108 ++++++++++
 2 files changed

// File: rtl/athos_pkg.sv
// Shared types and constants for the ATHOS Kyber datapath.
// Holds the encode-width type, legal widths and the packer state encoding.
package athos_pkg;

   typedef logic [3:0] pack_d_t;

   localparam pack_d_t PACK_D1  = 4'd1;
   localparam pack_d_t PACK_D4  = 4'd4;
   localparam pack_d_t PACK_D5  = 4'd5;
   localparam pack_d_t PACK_D10 = 4'd10;
   localparam pack_d_t PACK_D11 = 4'd11;
   localparam pack_d_t PACK_D12 = 4'd12;

   localparam int N_COEFFS = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pack_state_e;

   function automatic logic is_legal_d(input pack_d_t d);
      logic legal;
      case (d)
         PACK_D1, PACK_D4, PACK_D5, PACK_D10, PACK_D11, PACK_D12: legal = 1'b1;
         default:                                                 legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/poly_pack.sv
// Streaming ByteEncode_d packer: one d-bit coefficient in per handshake,
// little-endian 32-bit words out, one 256-coefficient polynomial per start.
//
// state | meaning
// IDLE  | waiting for start_i; no input accepted, no words offered
// RUN   | accepting coefficients and emitting full words
// DRAIN | all coefficients in; emitting the remaining buffered words
module poly_pack
   import athos_pkg::*;
#(
   parameter int CW    = 12,
   parameter int WW    = 32,
   parameter int BUF_W = 44
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [3:0]    d_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   input  logic          coef_valid_i,
   output logic          coef_ready_o,
   input  logic [CW-1:0] coef_i,
   output logic          word_valid_o,
   input  logic          word_ready_i,
   output logic [WW-1:0] word_o
);

   pack_state_e      state_q;
   pack_d_t          d_q;
   logic [BUF_W-1:0] buf_q, buf_d, buf_shift, coef_ext;
   logic [5:0]       bit_cnt_q, bit_cnt_d, cnt_shift;
   logic [8:0]       coef_cnt_q;
   logic             busy_q, done_q, err_q;
   logic             in_fire, out_fire;
   logic [CW:0]      mask_full;
   logic [CW-1:0]    coef_masked;

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;

   // Word side depends on registered state only, never on word_ready_i.
   assign word_valid_o = (bit_cnt_q >= 6'(WW));
   assign word_o       = buf_q[WW-1:0];
   assign out_fire     = word_valid_o && word_ready_i;

   assign coef_ready_o = (state_q == RUN) && (coef_cnt_q < 9'(N_COEFFS)) &&
                         ((bit_cnt_q <= 6'(WW - 1)) || out_fire);
   assign in_fire      = coef_valid_i && coef_ready_o;

   always_comb begin
      mask_full   = ((CW+1)'(1) << d_q) - (CW+1)'(1);
      coef_masked = coef_i & mask_full[CW-1:0];
      buf_shift   = out_fire ? (buf_q >> WW) : buf_q;
      cnt_shift   = out_fire ? (bit_cnt_q - 6'(WW)) : bit_cnt_q;
      coef_ext    = BUF_W'(coef_masked) << cnt_shift;
      buf_d       = in_fire ? (buf_shift | coef_ext) : buf_shift;
      bit_cnt_d   = in_fire ? (cnt_shift + 6'(d_q)) : cnt_shift;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         d_q        <= '0;
         buf_q      <= '0;
         bit_cnt_q  <= '0;
         coef_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         buf_q     <= buf_d;
         bit_cnt_q <= bit_cnt_d;
         if (in_fire) coef_cnt_q <= coef_cnt_q + 9'd1;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (is_legal_d(d_i)) begin
                     d_q        <= d_i;
                     busy_q     <= 1'b1;
                     coef_cnt_q <= '0;
                     state_q    <= RUN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (in_fire && (coef_cnt_q == 9'(N_COEFFS - 1))) state_q <= DRAIN;
            end
            DRAIN: begin
               // 256*d is a multiple of 32, so the buffer empties exactly on a word fire.
               if (out_fire && (bit_cnt_d == 6'd0)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
